// File: rtl/uart_pkg.sv
// Shared state type, register offsets and STATUS bit positions for the MMIO UART transmitter.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_e;

    localparam logic [2:0] TXDATA_OFS = 3'h0;
    localparam logic [2:0] STATUS_OFS = 3'h4;

    localparam int STAT_FULL     = 0;
    localparam int STAT_EMPTY    = 1;
    localparam int STAT_BUSY     = 2;
    localparam int STAT_OVERFLOW = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA stores feed a FIFO that is serialised 8N1 on tx.
// Build option: UART_TX_PARITY_EN adds an even-parity bit (8E1 framing).
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        sel,
    output logic        tx,
    output logic        busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic        is_status;
    logic        push_req;
    logic        clr_overflow;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        bit_end;
    logic        load;
    logic [31:0] status_word;
    logic        unused_ok;

    assign sel          = (A[31:3] == BASE_ADDR[31:3]);
    assign is_status    = ({A[2], 2'b00} == STATUS_OFS);
    assign push_req     = sel && WE && ({A[2], 2'b00} == TXDATA_OFS);
    assign clr_overflow = sel && WE && is_status && WD[STAT_OVERFLOW];
    assign unused_ok    = ^{WD[31:8], WD[6:4], WD[2:0], A[1:0]};

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push_req),
        .push_data(WD[7:0]),
        .pop      (fifo_pop),
        .pop_data (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign busy = (state_q != IDLE) || !fifo_empty;
    assign tx   = tx_q;

    always_comb begin
        status_word                = '0;
        status_word[STAT_FULL]     = fifo_full;
        status_word[STAT_EMPTY]    = fifo_empty;
        status_word[STAT_BUSY]     = busy;
        status_word[STAT_OVERFLOW] = overflow_q;
        RD = (sel && is_status) ? status_word : 32'h0;
    end

    assign bit_end = (baud_q == BAUD_LAST);

    // Next-state logic; a pop at the end of STOP chains straight into START so frames run back to back.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        overflow_d = overflow_q;
        fifo_pop   = 1'b0;
        load       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        if (push_req && fifo_full) overflow_d = 1'b1;
        else if (clr_overflow)     overflow_d = 1'b0;

        if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + BAUD_ONE;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (load) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            state_d  = START;
            baud_d   = '0;
            tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stores queue expected bytes, a line monitor decodes tx frames.
// Build option: UART_TX_PARITY_EN must match the RTL build so frame length and parity checks line up.
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = CPB * NBITS;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        WE      = 1'b0;
    logic [31:0] A       = 32'h0;
    logic [31:0] WD      = 32'h0;
    logic [31:0] RD;
    logic        sel;
    logic        tx;
    logic        busy;

    int         checkCount = 0;
    int         passCount  = 0;
    logic [7:0] sbQueue[$];
    logic [7:0] ovBytes[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'hEE};
    logic       lastParity = 1'b0;

    bit             monInFrame = 1'b0;
    int             monCyc     = 0;
    logic [NBITS-1:0] monBits  = '0;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .A      (A),
        .WE     (WE),
        .WD     (WD),
        .RD     (RD),
        .sel    (sel),
        .tx     (tx),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 32'h%08h, expected 32'h%08h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        A  = addr;
        WD = data;
        WE = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
        A  = 32'h0;
        WD = 32'h0;
    endtask

    task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
        A = addr;
        #1;
        data = RD;
        A = 32'h0;
    endtask

    task automatic waitIdle(input string name, input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, 32'(busy), 32'h0);
    endtask

    task automatic checkFrame(input logic [NBITS-1:0] bits);
        logic [7:0] exp;
        if (sbQueue.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL unexpectedFrame: got frame bits %b, expected no frame", bits);
        end else begin
            exp = sbQueue.pop_front();
            checkOutput("frameStart", 32'(bits[0]), 32'h0);
            checkOutput("frameData", 32'(bits[8:1]), 32'(exp));
`ifdef UART_TX_PARITY_EN
            lastParity = bits[9];
            checkOutput("frameParity", 32'(bits[9]), 32'(^exp));
`endif
            checkOutput("frameStop", 32'(bits[NBITS-1]), 32'h1);
        end
    endtask

    // Line monitor: a low level while idle opens a frame, each bit is sampled one cycle into its slot.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                monInFrame = 1'b0;
            end else begin
                if (!monInFrame && tx === 1'b0) begin
                    monInFrame = 1'b1;
                    monCyc     = 0;
                end
                if (monInFrame) begin
                    if (monCyc % CPB == 1) monBits[monCyc / CPB] = tx;
                    monCyc++;
                    if (monCyc == FRAME) begin
                        monInFrame = 1'b0;
                        checkFrame(monBits);
                    end
                end
            end
        end
    end

    task automatic singleFrame(input logic [7:0] data);
        sbQueue.push_back(data);
        applyStimulus(BASE, 32'(data));
        checkOutput("txBeforePop", 32'(tx), 32'h1);
        checkOutput("busyAfterPush", 32'(busy), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("frameStartLatency", 32'(tx), 32'h0);
        repeat (FRAME - 1) @(posedge clk);
        #1;
        checkOutput("busyLastStopCycle", 32'(busy), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("busyFall", 32'(busy), 32'h0);
        checkOutput("txIdleAfterFrame", 32'(tx), 32'h1);
    endtask

    initial begin : stimulus
        logic [31:0] rd;
        bit          noisy;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetTx", 32'(tx), 32'h1);
        checkOutput("resetBusy", 32'(busy), 32'h0);
        readReg(BASE + 32'h4, rd);
        checkOutput("resetStatus", rd, 32'h2);
        readReg(BASE, rd);
        checkOutput("txdataReadsZero", rd, 32'h0);
        A = 32'h0000_0010;
        #1;
        checkOutput("selOutside", 32'(sel), 32'h0);
        checkOutput("rdOutside", RD, 32'h0);
        A = BASE + 32'h4;
        #1;
        checkOutput("selInside", 32'(sel), 32'h1);
        A = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] single byte 0xA5");
        singleFrame(8'hA5);
        repeat (2) @(posedge clk);

        $display("[TB] back-to-back 0x55, 0x0F");
        sbQueue.push_back(8'h55);
        sbQueue.push_back(8'h0F);
        applyStimulus(BASE, 32'h55);
        applyStimulus(BASE, 32'h0F);
        repeat (FRAME) @(posedge clk);
        #1;
        readReg(BASE + 32'h4, rd);
        checkOutput("statusAfterSecondPop", rd, 32'h6);
        checkOutput("noIdleGap", 32'(tx), 32'h0);
        waitIdle("drainBackToBack", 4 * FRAME);

        $display("[TB] overflow");
        for (int i = 0; i < 6; i++) begin
            if (i < 5) sbQueue.push_back(ovBytes[i]);
            applyStimulus(BASE, 32'(ovBytes[i]));
        end
        readReg(BASE + 32'h4, rd);
        checkOutput("statusOverflowSet", rd, 32'hD);
        applyStimulus(BASE + 32'h4, 32'h8);
        readReg(BASE + 32'h4, rd);
        checkOutput("statusOverflowCleared", rd, 32'h5);
        waitIdle("drainOverflow", 8 * FRAME);
        checkOutput("scoreboardDrained", 32'(sbQueue.size()), 32'h0);
        repeat (2) @(posedge clk);

        $display("[TB] reset mid-frame");
        applyStimulus(BASE, 32'hC3);
        repeat (18) @(posedge clk);
        #1;
        checkOutput("txDataBit3", 32'(tx), 32'h0);
        reset_n = 1'b0;
        #1;
        checkOutput("asyncResetTx", 32'(tx), 32'h1);
        readReg(BASE + 32'h4, rd);
        checkOutput("statusInReset", rd, 32'h2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        noisy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) noisy = 1'b1;
        end
        checkOutput("quietAfterReset", 32'(noisy), 32'h0);

`ifdef UART_TX_PARITY_EN
        $display("[TB] parity byte 0x07");
        singleFrame(8'h07);
        checkOutput("parityBit", 32'(lastParity), 32'h1);
`endif

        repeat (5) @(posedge clk);
        checkOutput("scoreboardEmpty", 32'(sbQueue.size()), 32'h0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected stimulus to complete");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
